pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register; successor to the fixed-field stage registers (IF/ID..MEM/WB).
//  - Carries a control bundle and a data bundle with valid/ready handshake, 2-entry skid, flush (bubble insertion), debug step gating.
//  - Lets hazard/stall logic backpressure a stage without combinational ready paths.
//  - One instance per stage boundary; widths set per instance.
// PARAMETERS
//  NB_CTRL  = 8   width of control bundle (mem_read, mem_write, reg_write, word_size...); zeroed when bubble
//  NB_DATA  = 96  width of data bundle (alu_result, data_b, branch_addr...); not zeroed on bubble
//  NB_CNT   = 16  width of statistics counters (PIPE_REG_STATS_EN only)
// PORTS
//  i_clk        in   1        clock; all state updates on FALLING edge (pipeline convention)
//  i_reset_n    in   1        asynchronous reset, active-low
//  i_step       in   1        debug step enable; 0 freezes all state (flush included)
//  i_flush      in   1        discard both entries (branch taken / exception)
//  i_valid      in   1        upstream entry valid
//  o_ready      out  1        stage can accept an entry
//  i_ctrl       in   NB_CTRL  upstream control bundle
//  i_data       in   NB_DATA  upstream data bundle
//  o_valid      out  1        output entry valid
//  i_ready      in   1        downstream accepts
//  o_ctrl       out  NB_CTRL  control bundle; forced 0 when o_valid=0
//  o_data       out  NB_DATA  data bundle (holds last value when invalid)
//  o_occupancy  out  2        entries held: 0,1,2
//  o_stall_cnt  out  NB_CNT   cycles with o_valid & !i_ready & i_step (macro only)
//  o_flush_cnt  out  NB_CNT   flushes applied that discarded >=1 entry (macro only)
// BEHAVIOUR
//  - Async reset (i_reset_n=0): state EMPTY, o_valid=0, o_ready=1, o_ctrl=0, o_data=0, skid=0, o_occupancy=0, counters=0.
//  - push = i_valid & o_ready & i_step; pop = o_valid & i_ready & i_step.
//  - States: EMPTY (out reg free), ONE (out reg valid, skid empty), FULL (both valid).
//   EMPTY: push -> ONE, out<=in.
//   ONE: push&!pop -> FULL, skid<=in; push&pop -> ONE, out<=in; !push&pop -> EMPTY; else hold.
//   FULL: pop -> ONE, out<=skid; push impossible (o_ready=0).
//  - o_ready = (state!=FULL): decoded from state register only, no comb path from i_ready/i_valid.
//  - Latency: 1 falling edge from push to o_valid when EMPTY/popping; skid entry seen 1 edge after pop.
//  - Order preserved: skid entry never overtakes out reg.
//  - i_flush & i_step: next state EMPTY; same-edge push and pop both discarded; flush dominates all.
//  - i_step=0: no state change, outputs stable; i_flush ignored.
//  - Async reset mid-transfer: entries dropped immediately, no partial update.
// CONFIGURATION
//  PIPE_REG_STATS_EN defined: o_stall_cnt, o_flush_cnt present; saturate at all-ones, never wrap.
//  Undefined: both ports absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  - Shared package pipe_pkg: state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2), default widths, NB_SIZE_TYPE=3.
//  - Sub-module pipe_sat_counter (NB_CNT, inc, clear via reset, saturating); instantiated twice under macro.
//  - Datapath: out reg + skid reg, each NB_CTRL+NB_DATA; FSM in this module.
// TESTING
//  1 Reset: i_reset_n=0 mid-FULL, no clock -> o_valid=0, o_ready=1, o_ctrl=0, o_occupancy=0 at once.
//  2 Streaming: i_valid=1, i_ready=1, i_step=1, data 1,2,3 -> o_data 1,2,3 on successive edges, occupancy 1.
//  3 Backpressure: i_ready=0, push 0xA then 0xB -> occupancy 2, o_ready=0; i_ready=1 -> 0xA then 0xB out, no loss/dup.
//  4 Flush: FULL, i_flush=1 with i_valid=1 data 0xC -> EMPTY, o_valid=0, o_ctrl=0, 0xC never out; o_flush_cnt=1 (macro).
//  5 Step freeze: i_step=0 with i_valid=1,i_ready=1,i_flush=1 for 5 edges -> state/outputs unchanged.
//  6 Stats (macro, NB_CNT=2): 5 stall cycles -> o_stall_cnt=3 (saturated); macro undefined -> build without ports passes 1-5.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage register:
// state encoding, default bundle widths and an occupancy decoder.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int NB_CTRL_DEF  = 8;
    localparam int NB_DATA_DEF  = 96;
    localparam int NB_CNT_DEF   = 16;
    localparam int NB_SIZE_TYPE = 3;

    function automatic logic [1:0] occupancy_of(input pipe_state_e state);
        logic [1:0] occ;
        case (state)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle of one pipeline stage boundary: upstream push side,
// downstream pop side and the step/flush controls from hazard/debug logic.
interface pipe_stage_reg_if #(
    parameter int NB_CTRL = 8,
    parameter int NB_DATA = 96
);
    logic               i_step;
    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_DATA-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [NB_CTRL-1:0] o_ctrl;
    logic [NB_DATA-1:0] o_data;
    logic [1:0]         o_occupancy;

    modport master (
        output i_step, i_flush, i_valid, i_ctrl, i_data, i_ready,
        input  o_ready, o_valid, o_ctrl, o_data, o_occupancy
    );

    modport slave (
        input  i_step, i_flush, i_valid, i_ctrl, i_data, i_ready,
        output o_ready, o_valid, o_ctrl, o_data, o_occupancy
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter clocked on the falling edge; cleared only by reset.
module pipe_sat_counter #(
    parameter int NB_CNT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_inc,
    output logic [NB_CNT-1:0] o_count
);

    logic [NB_CNT-1:0] cnt_r;

    // Count up on each event, sticking at all-ones instead of wrapping.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r <= '0;
        end else if (i_inc && (cnt_r != {NB_CNT{1'b1}})) begin
            cnt_r <= cnt_r + NB_CNT'(1);
        end
    end

    assign o_count = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with 2-entry skid, flush and debug-step gating.
// Optional statistics counters are built when PIPE_REG_STATS_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int NB_CTRL = NB_CTRL_DEF,
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_CNT  = NB_CNT_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    pipe_stage_reg_if.slave   bus
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [NB_CNT-1:0] o_stall_cnt,
    output logic [NB_CNT-1:0] o_flush_cnt
`endif
);

    pipe_state_e        state_r;
    logic [NB_CTRL-1:0] out_ctrl_r;
    logic [NB_DATA-1:0] out_data_r;
    logic [NB_CTRL-1:0] skid_ctrl_r;
    logic [NB_DATA-1:0] skid_data_r;
    logic               push_s;
    logic               pop_s;
    logic               flush_s;

    // Handshake qualifiers; ready/valid come from the state register alone.
    always_comb begin
        flush_s = bus.i_flush & bus.i_step;
        push_s  = bus.i_valid & (state_r != ST_FULL) & bus.i_step;
        pop_s   = (state_r != ST_EMPTY) & bus.i_ready & bus.i_step;
    end

    // Stage FSM and datapath; control bundle is zeroed whenever a slot empties.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_EMPTY;
            out_ctrl_r  <= '0;
            out_data_r  <= '0;
            skid_ctrl_r <= '0;
            skid_data_r <= '0;
        end else if (flush_s) begin
            state_r     <= ST_EMPTY;
            out_ctrl_r  <= '0;
            skid_ctrl_r <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_r    <= ST_ONE;
                        out_ctrl_r <= bus.i_ctrl;
                        out_data_r <= bus.i_data;
                    end
                end
                ST_ONE: begin
                    if (push_s && !pop_s) begin
                        state_r     <= ST_FULL;
                        skid_ctrl_r <= bus.i_ctrl;
                        skid_data_r <= bus.i_data;
                    end else if (push_s && pop_s) begin
                        out_ctrl_r <= bus.i_ctrl;
                        out_data_r <= bus.i_data;
                    end else if (pop_s) begin
                        state_r    <= ST_EMPTY;
                        out_ctrl_r <= '0;
                    end
                end
                ST_FULL: begin
                    // Skid drains into the output slot so ordering is kept.
                    if (pop_s) begin
                        state_r     <= ST_ONE;
                        out_ctrl_r  <= skid_ctrl_r;
                        out_data_r  <= skid_data_r;
                        skid_ctrl_r <= '0;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_ctrl_r  <= '0;
                    skid_ctrl_r <= '0;
                end
            endcase
        end
    end

    assign bus.o_valid     = (state_r != ST_EMPTY);
    assign bus.o_ready     = (state_r != ST_FULL);
    assign bus.o_ctrl      = out_ctrl_r;
    assign bus.o_data      = out_data_r;
    assign bus.o_occupancy = occupancy_of(state_r);

`ifdef PIPE_REG_STATS_EN
    logic stall_inc_s;
    logic flush_inc_s;

    // A flush counts only if it throws away a held or arriving entry.
    always_comb begin
        stall_inc_s = (state_r != ST_EMPTY) & ~bus.i_ready & bus.i_step;
        flush_inc_s = flush_s & ((state_r != ST_EMPTY) | bus.i_valid);
    end

    pipe_sat_counter #(.NB_CNT(NB_CNT)) u_stall_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (stall_inc_s),
        .o_count   (o_stall_cnt)
    );

    pipe_sat_counter #(.NB_CNT(NB_CNT)) u_flush_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (flush_inc_s),
        .o_count   (o_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard of accepted entries.
// Build with PIPE_REG_STATS_EN to also exercise the saturating counters (NB_CNT=2).
module tb_pipe_stage_reg;

    localparam int NB_CTRL = 8;
    localparam int NB_DATA = 96;
`ifdef PIPE_REG_STATS_EN
    localparam int NB_CNT = 2;
`else
    localparam int NB_CNT = 16;
`endif
    localparam int MAX_CNT = (1 << NB_CNT) - 1;

    logic clk = 1'b1;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.NB_CTRL(NB_CTRL), .NB_DATA(NB_DATA)) bus ();

`ifdef PIPE_REG_STATS_EN
    logic [NB_CNT-1:0] stall_cnt;
    logic [NB_CNT-1:0] flush_cnt;
`endif

    pipe_stage_reg #(.NB_CTRL(NB_CTRL), .NB_DATA(NB_DATA), .NB_CNT(NB_CNT)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .bus         (bus)
`ifdef PIPE_REG_STATS_EN
        ,
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
`endif
    );

    logic [NB_CTRL+NB_DATA-1:0] q[$];
    int checks = 0;
    int errors = 0;
    int stall_m = 0;
    int flush_m = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic [NB_DATA-1:0] d);
        logic [7:0] low;
        low          = d[7:0];
        bus.i_valid  = v;
        bus.i_ready  = r;
        bus.i_data   = d;
        bus.i_ctrl   = low ^ 8'hA5;
    endtask

    task automatic check_outputs(input string tag);
        logic [NB_CTRL+NB_DATA-1:0] head;
        chk({tag, "_occ"},   {126'd0, bus.o_occupancy}, 128'(q.size()));
        chk({tag, "_valid"}, {127'd0, bus.o_valid}, {127'd0, (q.size() != 0)});
        chk({tag, "_ready"}, {127'd0, bus.o_ready}, {127'd0, (q.size() != 2)});
        if (q.size() != 0) begin
            head = q[0];
            chk({tag, "_data"}, 128'(bus.o_data), 128'(head[NB_DATA-1:0]));
            chk({tag, "_ctrl"}, 128'(bus.o_ctrl), 128'(head[NB_CTRL+NB_DATA-1:NB_DATA]));
        end else begin
            chk({tag, "_ctrl0"}, 128'(bus.o_ctrl), 128'd0);
        end
`ifdef PIPE_REG_STATS_EN
        chk({tag, "_stall_cnt"}, 128'(stall_cnt), 128'(stall_m));
        chk({tag, "_flush_cnt"}, 128'(flush_cnt), 128'(flush_m));
`endif
    endtask

    // Advance one falling edge: update the model from the current inputs, then compare.
    task automatic cycle(input string tag);
        bit fl, push, pop;
        fl   = bus.i_flush & bus.i_step;
        pop  = (q.size() > 0) & bus.i_ready & bus.i_step & !fl;
        push = bus.i_valid & (q.size() < 2) & bus.i_step & !fl;
        if (bus.i_step && q.size() > 0 && !bus.i_ready && stall_m < MAX_CNT) stall_m++;
        if (fl && (q.size() > 0 || bus.i_valid) && flush_m < MAX_CNT) flush_m++;
        if (fl) q.delete();
        if (pop) void'(q.pop_front());
        if (push) q.push_back({bus.i_ctrl, bus.i_data});
        @(negedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_step  = 1'b1;
        bus.i_flush = 1'b0;
        drive(1'b0, 1'b0, 96'd0);
        #3;
        check_outputs("reset");
        chk("reset_data", 128'(bus.o_data), 128'd0);
        #4 rst_n = 1'b1;

        // Streaming: one entry per edge, occupancy stays at 1.
        drive(1'b1, 1'b1, 96'd1); cycle("stream1");
        drive(1'b1, 1'b1, 96'd2); cycle("stream2");
        drive(1'b1, 1'b1, 96'd3); cycle("stream3");
        chk("stream_occ", {126'd0, bus.o_occupancy}, 128'd1);
        chk("stream_last", 128'(bus.o_data), 128'd3);
        drive(1'b0, 1'b1, 96'd0); cycle("stream_drain");

        // Backpressure: fill skid, offer a rejected entry, then drain in order.
        drive(1'b1, 1'b0, 96'hA); cycle("bp_a");
        drive(1'b1, 1'b0, 96'hB); cycle("bp_b");
        chk("bp_full_occ", {126'd0, bus.o_occupancy}, 128'd2);
        chk("bp_full_ready", {127'd0, bus.o_ready}, 128'd0);
        drive(1'b1, 1'b0, 96'hD); cycle("bp_reject");
        chk("bp_head_a", 128'(bus.o_data), 128'hA);
        drive(1'b0, 1'b1, 96'd0); cycle("bp_pop1");
        chk("bp_head_b", 128'(bus.o_data), 128'hB);
        cycle("bp_pop2");

        // Asynchronous reset while FULL, checked before any clock edge.
        drive(1'b1, 1'b0, 96'h11); cycle("rst_fill1");
        drive(1'b1, 1'b0, 96'h22); cycle("rst_fill2");
        drive(1'b0, 1'b0, 96'd0);
        rst_n = 1'b0;
        #1;
        q.delete();
        stall_m = 0;
        flush_m = 0;
        check_outputs("async_rst");
        chk("async_rst_occ", {126'd0, bus.o_occupancy}, 128'd0);
        chk("async_rst_ready", {127'd0, bus.o_ready}, 128'd1);
        chk("async_rst_data", 128'(bus.o_data), 128'd0);
        #1 rst_n = 1'b1;

        // Flush while FULL with a concurrent push of 0xC.
        drive(1'b1, 1'b0, 96'h31); cycle("fl_fill1");
        drive(1'b1, 1'b0, 96'h32); cycle("fl_fill2");
        bus.i_flush = 1'b1;
        drive(1'b1, 1'b1, 96'hC); cycle("flush");
        bus.i_flush = 1'b0;
        chk("flush_valid", {127'd0, bus.o_valid}, 128'd0);
        chk("flush_ctrl", 128'(bus.o_ctrl), 128'd0);
`ifdef PIPE_REG_STATS_EN
        chk("flush_cnt_one", 128'(flush_cnt), 128'd1);
`endif
        drive(1'b0, 1'b1, 96'd0); cycle("flush_after1");
        cycle("flush_after2");

        // Step freeze: FULL with every other input active for 5 edges.
        drive(1'b1, 1'b0, 96'h41); cycle("frz_fill1");
        drive(1'b1, 1'b0, 96'h42); cycle("frz_fill2");
        bus.i_step  = 1'b0;
        bus.i_flush = 1'b1;
        drive(1'b1, 1'b1, 96'h43);
        for (int i = 0; i < 5; i++) cycle("freeze");
        bus.i_step  = 1'b1;
        bus.i_flush = 1'b0;
        chk("freeze_occ", {126'd0, bus.o_occupancy}, 128'd2);
        chk("freeze_head", 128'(bus.o_data), 128'h41);
        drive(1'b0, 1'b1, 96'd0); cycle("frz_drain1");
        cycle("frz_drain2");

        // Stall counting: 5 stalled cycles with one entry held.
        drive(1'b1, 1'b0, 96'h51); cycle("stall_fill");
        drive(1'b0, 1'b0, 96'd0);
        for (int i = 0; i < 5; i++) cycle("stall");
`ifdef PIPE_REG_STATS_EN
        chk("stall_cnt_sat", 128'(stall_cnt), 128'd3);
`endif
        drive(1'b0, 1'b1, 96'd0); cycle("stall_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
